// File: rtl/mul_div_pkg.sv
// Shared constants, FSM state encoding and operation codes for the multiply/divide unit.
package mul_div_pkg;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned CNT_W  = 5;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        WRITE = 2'd2
    } state_e;

endpackage

// File: rtl/mul_div_if.sv
// Request/result bundle between the register file and the multiply/divide unit.
interface mul_div_if #(
    parameter int unsigned WIDTH  = mul_div_pkg::WIDTH,
    parameter int unsigned ADDR_W = mul_div_pkg::ADDR_W
);
    logic              start;
    logic              op;
    logic [WIDTH-1:0]  A;
    logic [WIDTH-1:0]  B;
    logic [ADDR_W-1:0] dest;
    logic [WIDTH-1:0]  C;
    logic [ADDR_W-1:0] Caddr;
    logic              load;
    logic [WIDTH-1:0]  hi;
    logic              busy;
    logic              dz;

    modport master (
        output start, op, A, B, dest,
        input  C, Caddr, load, hi, busy, dz
    );

    modport slave (
        input  start, op, A, B, dest,
        output C, Caddr, load, hi, busy, dz
    );
endinterface

// File: rtl/mul_div_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide on the {acc, lo} pair.
module mul_div_step #(
    parameter int unsigned WIDTH = mul_div_pkg::WIDTH
) (
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] lo_next
);
    import mul_div_pkg::*;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] rem_sub;
    logic             fits;

    always_comb begin
        // Multiply: acc is the product high half, lo holds the remaining multiplier bits.
        addend  = lo[0] ? a : '0;
        sum     = {1'b0, acc} + {1'b0, addend};
        // Divide: acc is the partial remainder, lo shifts dividend out and quotient in.
        shifted = {acc, lo[WIDTH-1]};
        rem_sub = shifted[WIDTH-1:0] - b;
        fits    = shifted >= {1'b0, b};

        if (op == OP_MUL) begin
            acc_next = sum[WIDTH:1];
            lo_next  = {sum[0], lo[WIDTH-1:1]};
        end else begin
            acc_next = fits ? rem_sub : shifted[WIDTH-1:0];
            lo_next  = {lo[WIDTH-2:0], fits};
        end
    end
endmodule

// File: rtl/mul_div_unit.sv
// Iterative 16-bit unsigned multiply/divide unit writing results back to a register file.
module mul_div_unit #(
    parameter int unsigned WIDTH  = mul_div_pkg::WIDTH,
    parameter int unsigned ADDR_W = mul_div_pkg::ADDR_W
) (
    input logic       clk,
    input logic       clear,
    mul_div_if.slave  bus
);
    import mul_div_pkg::*;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              op_q, op_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [ADDR_W-1:0] dest_q, dest_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic [WIDTH-1:0]  c_q, c_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [ADDR_W-1:0] caddr_q, caddr_d;
    logic              dz_q, dz_d;

    logic [WIDTH-1:0]  acc_step;
    logic [WIDTH-1:0]  lo_step;

    mul_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .op       (op_q),
        .a        (a_q),
        .b        (b_q),
        .acc      (acc_q),
        .lo       (lo_q),
        .acc_next (acc_step),
        .lo_next  (lo_step)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        dest_d  = dest_q;
        acc_d   = acc_q;
        lo_d    = lo_q;
        c_d     = c_q;
        hi_d    = hi_q;
        caddr_d = caddr_q;
        dz_d    = dz_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d   = bus.op;
                    a_d    = bus.A;
                    b_d    = bus.B;
                    dest_d = bus.dest;
                    cnt_d  = '0;
                    acc_d  = '0;
                    lo_d   = (bus.op == OP_DIV) ? bus.A : bus.B;
                    if (bus.op == OP_DIV && bus.B == '0) begin
                        // Divide by zero bypasses the iteration entirely.
                        state_d = WRITE;
                        c_d     = '1;
                        hi_d    = bus.A;
                        caddr_d = bus.dest;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                acc_d = acc_step;
                lo_d  = lo_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    state_d = WRITE;
                    cnt_d   = '0;
                    c_d     = lo_step;
                    hi_d    = acc_step;
                    caddr_d = dest_q;
                    dz_d    = 1'b0;
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= OP_MUL;
            a_q     <= '0;
            b_q     <= '0;
            dest_q  <= '0;
            acc_q   <= '0;
            lo_q    <= '0;
            c_q     <= '0;
            hi_q    <= '0;
            caddr_q <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            dest_q  <= dest_d;
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            c_q     <= c_d;
            hi_q    <= hi_d;
            caddr_q <= caddr_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.C     = c_q;
    assign bus.Caddr = caddr_q;
    assign bus.hi    = hi_q;
    assign bus.dz    = dz_q;
    assign bus.busy  = (state_q != IDLE);
    // A clear arriving during WRITE suppresses the strobe so the aborted result is never written.
    assign bus.load  = (state_q == WRITE) && !clear;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench: stimulus pushes expected write-backs, a negedge monitor checks each load.
module tb_mul_div_unit;
    import mul_div_pkg::*;

    logic clk = 1'b0;
    logic clear;

    mul_div_if bus ();

    mul_div_unit #(
        .WIDTH  (16),
        .ADDR_W (4)
    ) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] c;
        logic [15:0] hi;
        logic [3:0]  addr;
        logic        dz;
        int          at;
    } exp_t;

    typedef struct packed {
        logic        op;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  d;
        logic [15:0] c;
        logic [15:0] hi;
    } vec_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic prev_load = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every load must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.load === 1'b1) begin
            chk("load_single_cycle", prev_load, 1'b0);
            if (sb.size() == 0) begin
                chk("unexpected_load", 1'b1, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("C", bus.C, e.c);
                chk("hi", bus.hi, e.hi);
                chk("Caddr", bus.Caddr, e.addr);
                chk("dz", bus.dz, e.dz);
                chk("load_cycle", cyc, e.at);
            end
        end
        prev_load = (bus.load === 1'b1);
    end

    task automatic issue(input logic o, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] d, input bit expect_result,
                         input logic [15:0] ec, input logic [15:0] eh,
                         input logic edz, input int lat);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = o;
        bus.A     = a;
        bus.B     = b;
        bus.dest  = d;
        @(posedge clk);
        #1;
        if (expect_result) sb.push_back('{c: ec, hi: eh, addr: d, dz: edz, at: cyc + lat});
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input bit scramble);
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.busy !== 1'b0) && n < 40) begin
            @(negedge clk);
            if (scramble) begin
                bus.A    = 16'($urandom);
                bus.B    = 16'($urandom);
                bus.op   = 1'($urandom);
                bus.dest = 4'($urandom);
            end
            #1;
            n++;
        end
        chk("completed_in_time", (n < 40), 1'b1);
    endtask

    vec_t vecs [6];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{op: OP_MUL, a: 16'h1234, b: 16'h0100, d: 4'd1, c: 16'h3400, hi: 16'h0012};
        vecs[1] = '{op: OP_DIV, a: 16'hFFFF, b: 16'h0001, d: 4'd2, c: 16'hFFFF, hi: 16'h0000};
        vecs[2] = '{op: OP_DIV, a: 16'h0005, b: 16'h0009, d: 4'd3, c: 16'h0000, hi: 16'h0005};
        vecs[3] = '{op: OP_DIV, a: 16'hFFFF, b: 16'hFFFF, d: 4'd4, c: 16'h0001, hi: 16'h0000};
        vecs[4] = '{op: OP_DIV, a: 16'h8000, b: 16'h0003, d: 4'd5, c: 16'h2AAA, hi: 16'h0002};
        vecs[5] = '{op: OP_MUL, a: 16'h0000, b: 16'hABCD, d: 4'd6, c: 16'h0000, hi: 16'h0000};

        clear     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        bus.dest  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_C", bus.C, 16'h0);
        chk("reset_hi", bus.hi, 16'h0);
        chk("reset_Caddr", bus.Caddr, 4'h0);
        chk("reset_load", bus.load, 1'b0);
        chk("reset_busy", bus.busy, 1'b0);
        chk("reset_dz", bus.dz, 1'b0);
        clear = 1'b0;

        issue(OP_MUL, 16'd3, 16'd5, 4'd2, 1'b1, 16'h000F, 16'h0000, 1'b0, 16);
        @(negedge clk);
        chk("busy_after_accept", bus.busy, 1'b1);
        wait_done(1'b0);
        chk("busy_after_done", bus.busy, 1'b0);

        issue(OP_MUL, 16'hFFFF, 16'hFFFF, 4'd5, 1'b1, 16'h0001, 16'hFFFE, 1'b0, 16);
        wait_done(1'b0);
        issue(OP_DIV, 16'd100, 16'd7, 4'd9, 1'b1, 16'h000E, 16'h0002, 1'b0, 16);
        wait_done(1'b0);

        // Divide by zero: one-cycle busy, immediate write-back, dz sticks afterwards.
        issue(OP_DIV, 16'h1234, 16'h0000, 4'd3, 1'b1, 16'hFFFF, 16'h1234, 1'b1, 0);
        @(negedge clk);
        chk("dz_busy_first", bus.busy, 1'b1);
        @(negedge clk);
        chk("dz_busy_second", bus.busy, 1'b0);
        repeat (3) @(negedge clk);
        chk("dz_hold", bus.dz, 1'b1);
        chk("C_hold", bus.C, 16'hFFFF);
        chk("hi_hold", bus.hi, 16'h1234);
        wait_done(1'b0);

        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].d, 1'b1,
                  vecs[i].c, vecs[i].hi, 1'b0, 16);
            wait_done(1'b0);
        end

        // Operands scrambled every cycle after acceptance.
        issue(OP_MUL, 16'h00C8, 16'h012C, 4'd7, 1'b1, 16'hEA60, 16'h0000, 1'b0, 16);
        wait_done(1'b1);
        issue(OP_DIV, 16'hC350, 16'h007B, 4'd8, 1'b1, 16'h0196, 16'h003E, 1'b0, 16);
        wait_done(1'b1);

        // Second start four cycles after acceptance is dropped.
        issue(OP_MUL, 16'd7, 16'd9, 4'd1, 1'b1, 16'h003F, 16'h0000, 1'b0, 16);
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_DIV;
        bus.A     = 16'd50;
        bus.B     = 16'd5;
        bus.dest  = 4'd12;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(1'b0);
        repeat (20) @(negedge clk);

        // Start presented in the WRITE cycle is dropped.
        issue(OP_MUL, 16'd2, 16'd3, 4'd4, 1'b1, 16'h0006, 16'h0000, 1'b0, 16);
        repeat (16) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.op    = OP_MUL;
        bus.A     = 16'd11;
        bus.B     = 16'd13;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        chk("start_in_write_ignored", bus.busy, 1'b0);
        repeat (20) @(negedge clk);
        chk("queue_empty_after_write_start", sb.size(), 0);

        // Clear sampled at t+8 aborts the operation.
        issue(OP_MUL, 16'd3, 16'd5, 4'd7, 1'b0, 16'h0, 16'h0, 1'b0, 16);
        repeat (8) @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        @(negedge clk);
        chk("clear_run_busy", bus.busy, 1'b0);
        chk("clear_run_load", bus.load, 1'b0);
        chk("clear_run_C", bus.C, 16'h0);
        chk("clear_run_Caddr", bus.Caddr, 4'h0);
        repeat (20) @(negedge clk);

        // Clear raised during WRITE suppresses the strobe.
        issue(OP_DIV, 16'd100, 16'd7, 4'd9, 1'b0, 16'h0, 16'h0, 1'b0, 16);
        repeat (16) @(posedge clk);
        #1;
        clear = 1'b1;
        @(negedge clk);
        chk("clear_write_load", bus.load, 1'b0);
        @(posedge clk);
        #1;
        clear = 1'b0;
        @(negedge clk);
        chk("clear_write_busy", bus.busy, 1'b0);
        chk("clear_write_hi", bus.hi, 16'h0);

        // Clear wins over a simultaneous start.
        @(negedge clk);
        clear     = 1'b1;
        bus.start = 1'b1;
        bus.op    = OP_MUL;
        bus.A     = 16'd1;
        bus.B     = 16'd1;
        @(posedge clk);
        #1;
        clear     = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        chk("clear_over_start", bus.busy, 1'b0);
        repeat (20) @(negedge clk);

        issue(OP_MUL, 16'h00FF, 16'h00FF, 4'd15, 1'b1, 16'hFE01, 16'h0000, 1'b0, 16);
        wait_done(1'b0);
        chk("queue_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width; the only supported value is 16.
REQ-002 Parameter ADDR_W, default 4, register-file address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 clear  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request a new operation; sampled only in IDLE.
REQ-006 op  input  1  0 = unsigned multiply, 1 = unsigned divide.
REQ-007 A  input  16  multiplicand / dividend, from register-file read port A.
REQ-008 B  input  16  multiplier / divisor, from register-file read port B.
REQ-009 dest  input  4  destination register address for the result.
REQ-010 C  output  16  result to register-file write data.
REQ-011 Caddr  output  4  result address to register-file write address.
REQ-012 load  output  1  one-cycle write strobe to register-file load.
REQ-013 hi  output  16  product high half (multiply) or remainder (divide).
REQ-014 busy  output  1  high from the cycle after start acceptance through the WRITE cycle.
REQ-015 dz  output  1  divide-by-zero flag for the last completed operation.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and WRITE.
REQ-017 In IDLE with start=1 at edge t, the unit SHALL latch A, B, op and dest; later changes to these inputs SHALL NOT affect the result.
REQ-018 After acceptance with op=0, or op=1 with B!=0, the FSM SHALL enter RUN with a 5-bit iteration counter at 0.
REQ-019 RUN SHALL perform one radix-2 step per cycle for exactly 16 cycles, then enter WRITE.
- Multiply uses shift-add into a 32-bit product register.
- Divide uses restoring division on a 16-bit remainder and a 16-bit quotient.
REQ-020 WRITE SHALL last one cycle and assert load=1 together with valid C, Caddr=dest and hi.
- The FSM then returns to IDLE.
- Normal latency: load high in cycle t+17.
REQ-021 Multiply results: C = product[15:0], hi = product[31:16], with no overflow flag.
REQ-022 Divide results: C = quotient, hi = remainder, dz = 0.
REQ-023 Divide with latched B=0 SHALL skip RUN and go straight to WRITE with load high in cycle t+1.
- C = 16'hFFFF, hi = latched A, dz = 1.
REQ-024 start while busy=1 SHALL be ignored, with no queuing.
REQ-025 start asserted in the WRITE cycle SHALL be ignored; it is accepted again only once the FSM is in IDLE.
REQ-026 C, Caddr and hi SHALL hold their last WRITE values until the next WRITE.
REQ-027 dz SHALL hold until the next WRITE.
REQ-028 load SHALL never be high for more than one consecutive cycle.

Reset
REQ-029 clear=1 at any edge SHALL force IDLE, counter = 0, C = 0, Caddr = 0, hi = 0, load = 0, busy = 0, dz = 0.
REQ-030 clear asserted mid-RUN or in WRITE SHALL abort the operation with no load pulse; clear has priority over start.

Structure
REQ-031 A shared package mul_div_pkg SHALL hold the WIDTH/ADDR_W constants, the state enumeration (IDLE, RUN, WRITE) and the op encodings (OP_MUL = 0, OP_DIV = 1).
REQ-032 One sub-module, mul_div_step, SHALL implement the single-iteration combinational step for both ops; mul_div_unit SHALL hold the FSM, counter and registers.

Verification
REQ-033 Multiply: A=3, B=5, dest=2, start pulse -> load in cycle t+17 with C=0x000F, hi=0x0000, Caddr=2.
REQ-034 Multiply: A=0xFFFF, B=0xFFFF -> C=0x0001, hi=0xFFFE, dz=0.
REQ-035 Divide: A=100, B=7, dest=9 -> C=0x000E, hi=0x0002, Caddr=9, load at t+17.
REQ-036 Divide by zero: A=0x1234, B=0 -> load at t+1 with C=0xFFFF, hi=0x1234, dz=1, busy high for one cycle.
REQ-037 Busy and clear: a second start 4 cycles after acceptance is ignored, with exactly one load at t+17.
- clear at t+8 of a further operation gives no load, and busy=0 in the following cycle.
REQ-038 Operand isolation: A/B changed to random values every cycle after acceptance -> result matches the latched operands.
